// File: rtl/accelerator_pkg.sv
// Shared types, mode encodings and the saturating adder used by the
// accelerator_array controller and its lanes.
package accelerator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BIAS = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_RAW  = 2'd0;
    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_SIGN = 2'd2;

    // Operands are carried at SAT_W bits; callers truncate to their own width.
    localparam int SAT_W = 32;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             width
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = (33'sd1 <<< (width - 32'd1)) - 33'sd1;
        lo  = -hi - 33'sd1;
        if (sum > hi) begin
            sat_add = hi[SAT_W-1:0];
        end else if (sum < lo) begin
            sat_add = lo[SAT_W-1:0];
        end else begin
            sat_add = sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/accelerator_lane.sv
// One dot-product lane: exact beat-sum tree, saturating accumulator and the
// bias/mode output stage driven by controller strobes.
module accelerator_lane
    import accelerator_pkg::*;
#(
    parameter int IW   = 8,
    parameter int BW   = 16,
    parameter int SIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               acc_i,
    input  logic               clr_i,
    input  logic               fin_i,
    input  logic [1:0]         mode_i,
    input  logic [IW*SIZE-1:0] w_i,
    input  logic [IW*SIZE-1:0] x_i,
    input  logic [IW-1:0]      bias_i,
    output logic [BW-1:0]      y_o
);

    localparam int SW = 2*IW + $clog2(SIZE);

    logic signed [SW-1:0]    beat_sum_s;
    logic signed [IW-1:0]    wj_s;
    logic signed [IW-1:0]    xj_s;
    logic signed [2*IW-1:0]  prod_s;
    logic signed [SAT_W-1:0] acc_sum_s;
    logic signed [SAT_W-1:0] bias_sum_s;
    logic signed [BW-1:0]    res_s;
    logic        [BW-1:0]    shaped_s;
    logic signed [BW-1:0]    acc_q, acc_d;
    logic        [BW-1:0]    y_q, y_d;

    // Exact sum of signed products for the current beat
    always_comb begin
        beat_sum_s = '0;
        wj_s       = '0;
        xj_s       = '0;
        prod_s     = '0;
        for (int j = 0; j < SIZE; j++) begin
            wj_s       = w_i[j*IW +: IW];
            xj_s       = x_i[j*IW +: IW];
            prod_s     = wj_s * xj_s;
            beat_sum_s = beat_sum_s + SW'(prod_s);
        end
    end

    assign acc_sum_s  = sat_add(SAT_W'(acc_q), SAT_W'(beat_sum_s), BW);
    assign bias_sum_s = sat_add(SAT_W'(acc_q), SAT_W'(signed'(bias_i)), BW);
    assign res_s      = bias_sum_s[BW-1:0];

    // Accumulator next state; a disabled lane never leaves zero
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_i && en_i) begin
            acc_d = acc_sum_s[BW-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    // Output shaping; disabled lanes are forced to zero even in sign mode
    always_comb begin
        shaped_s = res_s;
        case (mode_i)
            MODE_RELU: shaped_s = res_s[BW-1] ? '0 : res_s;
            MODE_SIGN: shaped_s = res_s[BW-1] ? '1 : {{(BW-1){1'b0}}, 1'b1};
            default:   shaped_s = res_s;
        endcase
        if (fin_i) begin
            y_d = en_i ? shaped_s : '0;
        end else begin
            y_d = y_q;
        end
    end

    // Lane state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/accelerator_array.sv
// Multi-lane dot-product engine: start/busy controller, beat counter and
// valid/ready streaming into numUnit independent accelerator_lane instances.
module accelerator_array
    import accelerator_pkg::*;
#(
    parameter int inputBitwidth = 8,
    parameter int bitwidth      = 16,
    parameter int size          = 4,
    parameter int numUnit       = 4,
    parameter int numCycle      = 4,
    parameter int logNumCycle   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [1:0]                            mode,
    input  logic [numUnit-1:0]                    unit_en,
    input  logic [inputBitwidth*size*numUnit-1:0] data_in_w,
    input  logic [inputBitwidth*size*numUnit-1:0] data_in_x,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [inputBitwidth*numUnit-1:0]      bias,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [bitwidth*numUnit-1:0]           data_out_y,
    output logic                                  busy
);

    localparam int LW = inputBitwidth * size;

    state_e                   state_q, state_d;
    logic [logNumCycle-1:0]   cnt_q, cnt_d;
    logic [1:0]               mode_q, mode_d;
    logic [numUnit-1:0]       en_q, en_d;
    logic                     beat_s;
    logic                     last_beat_s;

    assign beat_s      = (state_q == ST_RUN) && in_valid;
    assign last_beat_s = (cnt_q == logNumCycle'(numCycle - 1));

    // Controller next state, beat counter and start-time captures
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        en_d    = en_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                mode_d = mode;
                en_d   = unit_en;
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (beat_s) begin
                    cnt_d = cnt_q + logNumCycle'(1'b1);
                    if (last_beat_s) state_d = ST_BIAS;
                    else             state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BIAS: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

    for (genvar i = 0; i < numUnit; i++) begin : g_lane
        accelerator_lane #(
            .IW   (inputBitwidth),
            .BW   (bitwidth),
            .SIZE (size)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (en_q[i]),
            .acc_i  (beat_s),
            .clr_i  (state_q == ST_IDLE),
            .fin_i  (state_q == ST_BIAS),
            .mode_i (mode_q),
            .w_i    (data_in_w[i*LW +: LW]),
            .x_i    (data_in_x[i*LW +: LW]),
            .bias_i (bias[i*inputBitwidth +: inputBitwidth]),
            .y_o    (data_out_y[i*bitwidth +: bitwidth])
        );
    end

endmodule

// File: doc/accelerator_array.md
# accelerator_array

Parametrised multi-lane dot-product engine for Axiline, next generation of the single-pass accelerator top. It instantiates `numUnit` independent lanes and adds a shared controller. The controller provides a start/busy interface, valid/ready streaming of `numCycle` input beats, per-lane enable, saturating accumulation, bias add, a selectable output mode and a held result with an output handshake. It sits between the input-staging buffers and the update stage.

## Interface
- `inputBitwidth`, 8, signed width of each w, x and bias element
- `bitwidth`, 16, signed width of accumulator and result
- `size`, 4, elements per lane per beat
- `numUnit`, 4, number of lanes
- `numCycle`, 4, beats per pass (≥1)
- `logNumCycle`, 2, beat-counter width; equals clog2(numCycle), minimum 1
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a pass; sampled only in IDLE
- `mode`  in  2  output mode, captured at start: 0 raw, 1 ReLU, 2 sign, 3 raw
- `unit_en`  in  numUnit  lane enable mask, captured at start
- `data_in_w`  in  inputBitwidth·size·numUnit  weights; lane i at slice i
- `data_in_x`  in  inputBitwidth·size·numUnit  features; same packing
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `bias`  in  inputBitwidth·numUnit  per-lane bias; sampled in BIAS state
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed
- `data_out_y`  out  bitwidth·numUnit  per-lane result; lane i at slice i
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, RUN, BIAS, DONE.
- IDLE:
  - `start`=1 → RUN.
  - Clears all accumulators and the beat counter.
  - Captures `mode` and `unit_en`.
- RUN:
  - `in_ready`=1.
  - Each accepted beat adds every enabled lane's beat sum to its accumulator, then increments the beat counter.
  - Acceptance of beat `numCycle-1` → BIAS.
  - Cycles without a handshake change nothing.
- BIAS (exactly one cycle):
  - Computes acc + sign-extended bias, saturated.
  - Applies the mode, registers the value into `data_out_y`, then → DONE.
- DONE:
  - `out_valid`=1; `data_out_y` is held stable.
  - `out_ready`=1 → IDLE on the same edge. `data_out_y` keeps its value until the next BIAS.
- Beat sum:
  - Σ w_j·x_j over `size` signed products.
  - Computed exactly at width 2·inputBitwidth + clog2(size).
- Saturation:
  - Every accumulate and every bias add clamps to [−2^(bitwidth−1), 2^(bitwidth−1)−1].
  - No wrap-around ever occurs.
- Modes:
  - ReLU outputs max(y,0).
  - Sign outputs +1 if y≥0, else −1 (all ones).
- Disabled lanes keep their accumulator at 0 and output 0 in every mode, including sign mode.
- `start` outside IDLE is ignored; it is not queued.
- `rst` in any state, mid-pass included:
  - → IDLE.
  - Accumulators, counter and `data_out_y` are cleared to 0.
  - Captured mode/enable are cleared to 0.
  - The partial pass is discarded.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `data_out_y`=0.
- Handshake-driving outputs (`in_ready`, `out_valid`, `busy`) are decoded from registered state only; no combinational path from inputs to outputs.
- The first beat can be accepted on the edge after the one that samples `start`.
- Latency:
  - The edge accepting the last beat enters BIAS.
  - The next edge enters DONE, so `out_valid` rises 2 edges after the last beat.
- Minimum pass, gap-free input: numCycle+3 edges from sampling `start` to re-entering IDLE with `out_ready` held high.
- `in_ready` is 0 in BIAS and DONE, so beats offered then are not consumed.
- `out_valid` stays high indefinitely while `out_ready`=0.

## Structure
- Package `accelerator_pkg` holds:
  - FSM state encoding.
  - Mode encoding constants (MODE_RAW, MODE_RELU, MODE_SIGN).
  - A saturating-add function parametrised by width.
- Sub-module `accelerator_lane`, one per lane, contains:
  - The beat-sum tree and the accumulator register.
  - The bias/mode stage.
  - Its inputs are accumulate/clear/finalise strobes from the controller.
- The controller FSM and beat counter live in `accelerator_array`.

## Test plan
All tests use inputBitwidth=8, bitwidth=16, size=4, numUnit=2, numCycle=4.
- All w=1, x=1, bias=3, mode 0, gap-free beats → both lanes 19; `out_valid` rises 2 edges after beat 4.
- All w=x=127, bias=0 → each beat sum is 64516; result saturates to 32767. All w=127, x=−128 → −32768.
- w=−1, x=2, bias=0 → mode 0 gives −32 (0xFFE0), mode 1 gives 0, mode 2 gives 0xFFFF.
- `in_valid` toggling every other cycle → result identical to the gap-free run (19); exactly 4 handshakes counted.
- `unit_en`=2'b01 → lane 1 outputs 0, lane 0 outputs 19.
- Boundary events:
  - `start` pulsed during RUN → ignored.
  - `rst` asserted after beat 2 → IDLE with all outputs 0; the next full pass returns 19.
  - `out_ready` held low 5 cycles in DONE → `out_valid` and data stable, `in_ready`=0.
